game_round_sequencer: RTL and testbench

- Generates per-round timing for the LED reaction game and drives the random LED controller directly downstream of it.
- Outputs consumed there: gerar_jogada, trigger, contador_jogo, mid_idx, max_idx.
- Sequences N_RODADAS rounds per game, sets round length by difficulty, and scores each player press against a window centred on mid_idx.

---
 rtl/game_round_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_game_round_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_round_sequencer.sv
// Round sequencer for the LED reaction game: times each round by difficulty,
// feeds the downstream random LED controller and scores player presses.
module game_round_sequencer #(
   parameter int unsigned N_RODADAS = 10,
   parameter logic [28:0] T_NIVEL0  = 29'd100_000_000,
   parameter logic [28:0] T_NIVEL1  = 29'd75_000_000,
   parameter logic [28:0] T_NIVEL2  = 29'd50_000_000,
   parameter logic [28:0] T_NIVEL3  = 29'd50_000_000,
   parameter logic [28:0] JANELA    = 29'd5_000_000,
   parameter logic [28:0] PAUSA     = 29'd25_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iniciar,
   input  logic        botao,
   input  logic [1:0]  nivel_dificuldade,
   output logic        gerar_jogada,
   output logic        trigger,
   output logic [28:0] contador_jogo,
   output logic [28:0] mid_idx,
   output logic [28:0] max_idx,
   output logic        acerto,
   output logic        erro,
   output logic [7:0]  acertos,
   output logic [7:0]  rodada,
   output logic        fim_jogo,
   output logic [2:0]  db_estado
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] PREPARA   = 3'd1;
   localparam logic [2:0] GERA      = 3'd2;
   localparam logic [2:0] CONTA     = 3'd3;
   localparam logic [2:0] AVALIA    = 3'd4;
   localparam logic [2:0] INTERVALO = 3'd5;
   localparam logic [2:0] FIM       = 3'd6;

   localparam logic [7:0] ULTIMA = 8'(N_RODADAS - 1);

   logic [2:0]  estado_q,  estado_d;
   logic [1:0]  nivel_q,   nivel_d;
   logic [28:0] max_q,     max_d;
   logic [28:0] mid_q,     mid_d;
   logic [28:0] cont_q,    cont_d;
   logic [28:0] pausa_q,   pausa_d;
   logic [7:0]  acertos_q, acertos_d;
   logic [7:0]  rodada_q,  rodada_d;
   logic        acerto_q,  acerto_d;
   logic        erro_q,    erro_d;
   logic        trigger_q, trigger_d;

   logic [28:0] tempo_sel;
   logic [28:0] tempo_m1;
   logic        hit;
   logic        pausa_fim;

   always_comb begin
      case (nivel_q)
         2'b00:   tempo_sel = T_NIVEL0;
         2'b01:   tempo_sel = T_NIVEL1;
         2'b10:   tempo_sel = T_NIVEL2;
         default: tempo_sel = T_NIVEL3;
      endcase
      tempo_m1 = tempo_sel - 29'd1;
   end

   // Window test widened to 30 bits so cont+JANELA and mid+JANELA cannot wrap.
   always_comb begin
      hit = (({1'b0, cont_q} + {1'b0, JANELA}) >= {1'b0, mid_q}) &&
            ({1'b0, cont_q} <= ({1'b0, mid_q} + {1'b0, JANELA}));
      pausa_fim = ({1'b0, pausa_q} + 30'd1) >= {1'b0, PAUSA};
   end

   always_comb begin
      estado_d  = estado_q;
      nivel_d   = nivel_q;
      max_d     = max_q;
      mid_d     = mid_q;
      cont_d    = cont_q;
      pausa_d   = pausa_q;
      acertos_d = acertos_q;
      rodada_d  = rodada_q;
      acerto_d  = 1'b0;
      erro_d    = 1'b0;
      trigger_d = 1'b0;

      case (estado_q)
         IDLE, FIM: begin
            if (iniciar) begin
               estado_d  = PREPARA;
               nivel_d   = nivel_dificuldade;
               acertos_d = '0;
               rodada_d  = '0;
            end
         end
         PREPARA: begin
            max_d    = tempo_m1;
            mid_d    = tempo_m1 >> 1;
            estado_d = GERA;
         end
         GERA: begin
            cont_d    = '0;
            trigger_d = 1'b1;
            estado_d  = CONTA;
         end
         CONTA: begin
            // A press on the final count beats the timeout.
            if (botao) begin
               acerto_d = hit;
               erro_d   = ~hit;
               estado_d = AVALIA;
            end else if (cont_q == max_q) begin
               erro_d   = 1'b1;
               pausa_d  = '0;
               estado_d = INTERVALO;
            end else begin
               cont_d = cont_q + 29'd1;
            end
         end
         AVALIA: begin
            if (acerto_q && (acertos_q != 8'hFF)) begin
               acertos_d = acertos_q + 8'd1;
            end
            pausa_d  = '0;
            estado_d = INTERVALO;
         end
         INTERVALO: begin
            if (pausa_fim) begin
               pausa_d = '0;
               if (rodada_q == ULTIMA) begin
                  estado_d = FIM;
               end else begin
                  rodada_d = rodada_q + 8'd1;
                  estado_d = GERA;
               end
            end else begin
               pausa_d = pausa_q + 29'd1;
            end
         end
         default: estado_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q  <= IDLE;
         nivel_q   <= '0;
         max_q     <= '0;
         mid_q     <= '0;
         cont_q    <= '0;
         pausa_q   <= '0;
         acertos_q <= '0;
         rodada_q  <= '0;
         acerto_q  <= 1'b0;
         erro_q    <= 1'b0;
         trigger_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         nivel_q   <= nivel_d;
         max_q     <= max_d;
         mid_q     <= mid_d;
         cont_q    <= cont_d;
         pausa_q   <= pausa_d;
         acertos_q <= acertos_d;
         rodada_q  <= rodada_d;
         acerto_q  <= acerto_d;
         erro_q    <= erro_d;
         trigger_q <= trigger_d;
      end
   end

   assign gerar_jogada  = (estado_q == GERA);
   assign trigger       = trigger_q;
   assign contador_jogo = cont_q;
   assign mid_idx       = mid_q;
   assign max_idx       = max_q;
   assign acerto        = acerto_q;
   assign erro          = erro_q;
   assign acertos       = acertos_q;
   assign rodada        = rodada_q;
   assign fim_jogo      = (estado_q == FIM);
   assign db_estado     = estado_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer using short round/pause parameters.
module tb_game_round_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        iniciar;
   logic        botao;
   logic [1:0]  nivel;
   logic        gerar_jogada;
   logic        trigger;
   logic [28:0] contador_jogo;
   logic [28:0] mid_idx;
   logic [28:0] max_idx;
   logic        acerto;
   logic        erro;
   logic [7:0]  acertos;
   logic [7:0]  rodada;
   logic        fim_jogo;
   logic [2:0]  db_estado;

   int vectors     = 0;
   int miscompares = 0;

   game_round_sequencer #(
      .N_RODADAS (3),
      .T_NIVEL0  (29'd100),
      .T_NIVEL1  (29'd80),
      .T_NIVEL2  (29'd60),
      .T_NIVEL3  (29'd40),
      .JANELA    (29'd5),
      .PAUSA     (29'd4)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .iniciar           (iniciar),
      .botao             (botao),
      .nivel_dificuldade (nivel),
      .gerar_jogada      (gerar_jogada),
      .trigger           (trigger),
      .contador_jogo     (contador_jogo),
      .mid_idx           (mid_idx),
      .max_idx           (max_idx),
      .acerto            (acerto),
      .erro              (erro),
      .acertos           (acertos),
      .rodada            (rodada),
      .fim_jogo          (fim_jogo),
      .db_estado         (db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_to(input logic [28:0] tgt);
      int unsigned n = 0;
      while (contador_jogo !== tgt && n < 300) begin
         tick();
         n++;
      end
      vectors++;
      if (contador_jogo !== tgt) begin miscompares++; $display("FAIL run_to: contador_jogo=%0d required %0d", contador_jogo, tgt); end
   endtask

   task automatic wait_gera();
      int unsigned n = 0;
      while (gerar_jogada !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (gerar_jogada !== 1'b1) begin miscompares++; $display("FAIL wait_gera: gerar_jogada=%b required 1", gerar_jogada); end
   endtask

   task automatic test_reset();
      reset = 1'b1; iniciar = 1'b0; botao = 1'b0; nivel = 2'b00;
      tick(); tick();
      vectors++; if (db_estado !== 3'd0) begin miscompares++; $display("FAIL reset_estado: got %0d required 0", db_estado); end
      vectors++; if ({gerar_jogada, trigger, acerto, erro, fim_jogo} !== 5'b0) begin miscompares++; $display("FAIL reset_pulses: got %b required 00000", {gerar_jogada, trigger, acerto, erro, fim_jogo}); end
      vectors++; if (contador_jogo !== 29'd0) begin miscompares++; $display("FAIL reset_contador: got %0d required 0", contador_jogo); end
      vectors++; if ({max_idx, mid_idx} !== 58'd0) begin miscompares++; $display("FAIL reset_idx: max=%0d mid=%0d required 0", max_idx, mid_idx); end
      vectors++; if ({acertos, rodada} !== 16'd0) begin miscompares++; $display("FAIL reset_counts: acertos=%0d rodada=%0d required 0", acertos, rodada); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_start_and_hit();
      nivel = 2'b00; iniciar = 1'b1;
      tick(); iniciar = 1'b0;
      vectors++; if (db_estado !== 3'd1) begin miscompares++; $display("FAIL start_prepara: estado=%0d required 1", db_estado); end
      vectors++; if (gerar_jogada !== 1'b0) begin miscompares++; $display("FAIL start_gera_early: gerar_jogada=%b required 0", gerar_jogada); end
      tick();
      vectors++; if (gerar_jogada !== 1'b1) begin miscompares++; $display("FAIL start_gera: gerar_jogada=%b required 1", gerar_jogada); end
      vectors++; if (max_idx !== 29'd99) begin miscompares++; $display("FAIL start_max: got %0d required 99", max_idx); end
      vectors++; if (mid_idx !== 29'd49) begin miscompares++; $display("FAIL start_mid: got %0d required 49", mid_idx); end
      tick();
      vectors++; if ({trigger, gerar_jogada} !== 2'b10) begin miscompares++; $display("FAIL start_trigger: trigger,gerar=%b required 10", {trigger, gerar_jogada}); end
      vectors++; if (contador_jogo !== 29'd0) begin miscompares++; $display("FAIL start_cont0: got %0d required 0", contador_jogo); end
      tick();
      vectors++; if ({trigger, contador_jogo} !== {1'b0, 29'd1}) begin miscompares++; $display("FAIL start_cont1: trigger=%b cont=%0d required 0/1", trigger, contador_jogo); end
      tick();
      vectors++; if (contador_jogo !== 29'd2) begin miscompares++; $display("FAIL start_cont2: got %0d required 2", contador_jogo); end
      run_to(29'd44);
      botao = 1'b1; tick(); botao = 1'b0;
      vectors++; if ({acerto, erro} !== 2'b10) begin miscompares++; $display("FAIL hit44: acerto,erro=%b required 10", {acerto, erro}); end
      vectors++; if ({db_estado, contador_jogo} !== {3'd4, 29'd44}) begin miscompares++; $display("FAIL hit44_avalia: estado=%0d cont=%0d required 4/44", db_estado, contador_jogo); end
      tick();
      vectors++; if ({acertos, acerto, db_estado} !== {8'd1, 1'b0, 3'd5}) begin miscompares++; $display("FAIL hit44_score: acertos=%0d acerto=%b estado=%0d required 1/0/5", acertos, acerto, db_estado); end
   endtask

   task automatic test_pause_and_ignore();
      botao = 1'b1; tick(); botao = 1'b0;
      vectors++; if ({db_estado, acerto, erro} !== {3'd5, 2'b00}) begin miscompares++; $display("FAIL pause_botao: estado=%0d acerto=%b erro=%b required 5/0/0", db_estado, acerto, erro); end
      tick(); tick();
      vectors++; if ({gerar_jogada, db_estado} !== {1'b0, 3'd5}) begin miscompares++; $display("FAIL pause_len: gerar=%b estado=%0d required 0/5", gerar_jogada, db_estado); end
      tick();
      vectors++; if ({gerar_jogada, rodada} !== {1'b1, 8'd1}) begin miscompares++; $display("FAIL pause_next: gerar=%b rodada=%0d required 1/1", gerar_jogada, rodada); end
   endtask

   task automatic test_miss();
      tick();
      run_to(29'd43);
      botao = 1'b1; tick(); botao = 1'b0;
      vectors++; if ({acerto, erro} !== 2'b01) begin miscompares++; $display("FAIL miss43: acerto,erro=%b required 01", {acerto, erro}); end
      tick();
      vectors++; if ({acertos, erro} !== {8'd1, 1'b0}) begin miscompares++; $display("FAIL miss43_score: acertos=%0d erro=%b required 1/0", acertos, erro); end
      wait_gera();
      vectors++; if (rodada !== 8'd2) begin miscompares++; $display("FAIL miss_rodada: got %0d required 2", rodada); end
   endtask

   task automatic test_timeout();
      tick();
      run_to(29'd99);
      vectors++; if ({db_estado, erro} !== {3'd3, 1'b0}) begin miscompares++; $display("FAIL timeout_pre: estado=%0d erro=%b required 3/0", db_estado, erro); end
      tick();
      vectors++; if ({erro, acerto, db_estado, contador_jogo} !== {2'b10, 3'd5, 29'd99}) begin miscompares++; $display("FAIL timeout_erro: erro=%b acerto=%b estado=%0d cont=%0d required 1/0/5/99", erro, acerto, db_estado, contador_jogo); end
      tick();
      vectors++; if ({erro, contador_jogo} !== {1'b0, 29'd99}) begin miscompares++; $display("FAIL timeout_hold: erro=%b cont=%0d required 0/99", erro, contador_jogo); end
      tick(); tick();
      vectors++; if (db_estado !== 3'd5) begin miscompares++; $display("FAIL timeout_pause: estado=%0d required 5", db_estado); end
      tick();
      vectors++; if ({fim_jogo, db_estado, rodada, acertos} !== {1'b1, 3'd6, 8'd2, 8'd1}) begin miscompares++; $display("FAIL fim: fim=%b estado=%0d rodada=%0d acertos=%0d required 1/6/2/1", fim_jogo, db_estado, rodada, acertos); end
      botao = 1'b1; tick(); tick(); botao = 1'b0;
      vectors++; if ({fim_jogo, acertos, contador_jogo, acerto, erro} !== {1'b1, 8'd1, 29'd99, 2'b00}) begin miscompares++; $display("FAIL fim_hold: fim=%b acertos=%0d cont=%0d acerto=%b erro=%b required 1/1/99/0/0", fim_jogo, acertos, contador_jogo, acerto, erro); end
   endtask

   task automatic test_restart_window();
      int unsigned n = 0;
      nivel = 2'b00; iniciar = 1'b1; tick(); iniciar = 1'b0;
      vectors++; if ({fim_jogo, acertos, rodada, db_estado} !== {1'b0, 8'd0, 8'd0, 3'd1}) begin miscompares++; $display("FAIL restart: fim=%b acertos=%0d rodada=%0d estado=%0d required 0/0/0/1", fim_jogo, acertos, rodada, db_estado); end
      wait_gera(); tick();
      run_to(29'd54);
      botao = 1'b1; tick(); botao = 1'b0;
      vectors++; if ({acerto, erro} !== 2'b10) begin miscompares++; $display("FAIL hit54: acerto,erro=%b required 10", {acerto, erro}); end
      wait_gera(); tick();
      run_to(29'd55);
      botao = 1'b1; tick(); botao = 1'b0;
      vectors++; if ({acerto, erro} !== 2'b01) begin miscompares++; $display("FAIL miss55: acerto,erro=%b required 01", {acerto, erro}); end
      wait_gera(); tick();
      run_to(29'd49);
      botao = 1'b1; tick(); botao = 1'b0;
      vectors++; if ({acerto, erro} !== 2'b10) begin miscompares++; $display("FAIL hit49: acerto,erro=%b required 10", {acerto, erro}); end
      while (fim_jogo !== 1'b1 && n < 30) begin tick(); n++; end
      vectors++; if ({fim_jogo, acertos, rodada} !== {1'b1, 8'd2, 8'd2}) begin miscompares++; $display("FAIL game2_fim: fim=%b acertos=%0d rodada=%0d required 1/2/2", fim_jogo, acertos, rodada); end
   endtask

   task automatic test_nivel3();
      nivel = 2'b11; iniciar = 1'b1; tick(); iniciar = 1'b0;
      nivel = 2'b00;
      wait_gera();
      vectors++; if ({max_idx, mid_idx} !== {29'd39, 29'd19}) begin miscompares++; $display("FAIL nivel3_idx: max=%0d mid=%0d required 39/19", max_idx, mid_idx); end
      tick();
      run_to(29'd39);
      botao = 1'b1; tick(); botao = 1'b0;
      vectors++; if ({db_estado, acerto, erro, contador_jogo} !== {3'd4, 2'b01, 29'd39}) begin miscompares++; $display("FAIL nivel3_edge: estado=%0d acerto=%b erro=%b cont=%0d required 4/0/1/39", db_estado, acerto, erro, contador_jogo); end
      tick();
      vectors++; if ({acertos, erro} !== {8'd0, 1'b0}) begin miscompares++; $display("FAIL nivel3_score: acertos=%0d erro=%b required 0/0", acertos, erro); end
      wait_gera();
      vectors++; if ({max_idx, rodada} !== {29'd39, 8'd1}) begin miscompares++; $display("FAIL nivel3_hold: max=%0d rodada=%0d required 39/1", max_idx, rodada); end
   endtask

   task automatic test_reset_midgame();
      tick();
      run_to(29'd30);
      #2 reset = 1'b1;
      #1;
      vectors++; if ({db_estado, contador_jogo, max_idx, mid_idx} !== {3'd0, 87'd0}) begin miscompares++; $display("FAIL async_reset_idx: estado=%0d cont=%0d max=%0d mid=%0d required 0", db_estado, contador_jogo, max_idx, mid_idx); end
      vectors++; if ({acertos, rodada, gerar_jogada, trigger, acerto, erro, fim_jogo} !== 21'd0) begin miscompares++; $display("FAIL async_reset_out: acertos=%0d rodada=%0d pulses=%b required 0", acertos, rodada, {gerar_jogada, trigger, acerto, erro, fim_jogo}); end
      tick();
      reset = 1'b0;
      botao = 1'b1; tick(); tick(); tick(); botao = 1'b0;
      vectors++; if ({db_estado, contador_jogo, acerto, erro} !== {3'd0, 29'd0, 2'b00}) begin miscompares++; $display("FAIL idle_botao: estado=%0d cont=%0d acerto=%b erro=%b required 0/0/0/0", db_estado, contador_jogo, acerto, erro); end
   endtask

   initial begin
      test_reset();
      test_start_and_hit();
      test_pause_and_ignore();
      test_miss();
      test_timeout();
      test_restart_window();
      test_nivel3();
      test_reset_midgame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
